axi4lite_sram_bridge: RTL and testbench

//   AXI4-Lite slave front-end for the single-port byte-enable SyncRam. Accepts
//   AXI4-Lite reads/writes, drives the SRAM raddr/waddr/wstrb/wdata ports and

---
 rtl/axi4lite_sram_bridge.sv | 199 +++++++++++++++++++
 tb/tb_axi4lite_sram_bridge.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_sram_bridge.sv
// ---------------------------------------------------------------------------
// Module: axi4lite_sram_bridge
//
// AXI4-Lite slave front-end for a single-port byte-enable SyncRam. Write and
// read paths run as two independent FSMs because the SRAM has separate
// write and read ports. The SRAM read latency is a fixed single cycle, and
// this block absorbs it before presenting the R channel.
//
// Optional feature macro: AXI_SRAM_MISALIGN_ERR_EN
//   defined   : accesses with addr[1:0] != 0 answer SLVERR (2'b10). Writes
//               commit with a zero strobe. Reads return zero data.
//   undefined : low address bits are ignored and every response is OKAY.
//
// Ports
//   clock, reset        : clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*     : AXI4-Lite write address / data / response channels
//   s_ar*/s_r*          : AXI4-Lite read address / data channels
//   sram_waddr/wstrb/wdata : SyncRam write port (strobe nonzero only in W_COMMIT)
//   sram_raddr/rdata    : SyncRam read port (rdata valid one cycle after raddr)
// ---------------------------------------------------------------------------
module axi4lite_sram_bridge #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_W = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [STRB_W-1:0]     s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [ADDR_WIDTH-1:0] sram_waddr,
    output logic [STRB_W-1:0]     sram_wstrb,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic [ADDR_WIDTH-1:0] sram_raddr,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    w_state_t              w_state;
    r_state_t              r_state;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  aw_err;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic                  ar_err;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic hazard;
    logic aw_misaligned;
    logic ar_misaligned;

    // Misalignment is only an error when the checking feature is built in.
    // Otherwise the flags are tied off and the low address bits pass to the
    // SRAM untouched.
`ifdef AXI_SRAM_MISALIGN_ERR_EN
    assign aw_misaligned = (s_awaddr[1:0] != 2'b00);
    assign ar_misaligned = (s_araddr[1:0] != 2'b00);
`else
    assign aw_misaligned = 1'b0;
    assign ar_misaligned = 1'b0;
`endif

    // The SRAM is read-first, so a read of the word being committed this
    // cycle would return stale data. The read is held off for one cycle,
    // which lets it see the new value.
    assign hazard = s_arvalid && (w_state == W_COMMIT) &&
                    (s_araddr[ADDR_WIDTH-1:2] == aw_addr[ADDR_WIDTH-1:2]);

    // Readies are forced low during reset so that nothing is accepted while
    // the FSMs are being cleared.
    assign s_awready = !reset && (w_state == W_IDLE) && !aw_held;
    assign s_wready  = !reset && (w_state == W_IDLE) && !w_held;
    assign s_arready = !reset && (r_state == R_IDLE) && !hazard;

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;

    // The write port always shows the latched beat. The strobe is opened
    // only during the single commit cycle, and only when the address is
    // acceptable, so the SRAM updates exactly once per write.
    assign sram_waddr = aw_addr;
    assign sram_wdata = w_data;
    assign sram_wstrb = (!reset && (w_state == W_COMMIT) && !aw_err) ? w_strb : '0;

    // The read address is forwarded combinationally on the handshake cycle so
    // that the SRAM data is ready one cycle later. Outside the handshake the
    // port holds the latched address.
    assign sram_raddr = ar_hs ? s_araddr : ar_addr;

    // Write FSM. AW and W are collected independently, in either order or in
    // the same cycle. Once both are held, the FSM spends one cycle driving
    // the SRAM and then offers the B response until it is taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state  <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            aw_err   <= 1'b0;
            s_bvalid <= 1'b0;
            s_bresp  <= 2'b00;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr <= s_awaddr;
                        aw_err  <= aw_misaligned;
                        aw_held <= 1'b1;
                    end
                    if (w_hs) begin
                        w_data <= s_wdata;
                        w_strb <= s_wstrb;
                        w_held <= 1'b1;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        w_state <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    s_bvalid <= 1'b1;
                    s_bresp  <= aw_err ? 2'b10 : 2'b00;
                    w_state  <= W_RESP;
                end
                W_RESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM. The address is accepted, then one cycle is spent waiting for
    // the SRAM output, which is captured. The captured data is held with
    // rvalid until the master takes it. A misaligned read still goes to the
    // SRAM, but the data it returns is discarded.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= R_IDLE;
            ar_addr  <= '0;
            ar_err   <= 1'b0;
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= 2'b00;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        ar_addr <= s_araddr;
                        ar_err  <= ar_misaligned;
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    s_rdata  <= ar_err ? '0 : sram_rdata;
                    s_rresp  <= ar_err ? 2'b10 : 2'b00;
                    s_rvalid <= 1'b1;
                    r_state  <= R_RESP;
                end
                R_RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        r_state  <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_sram_bridge.sv
// ---------------------------------------------------------------------------
// Testbench for axi4lite_sram_bridge.
// Contains a behavioural SyncRam: read-first, one-cycle read latency, with
// byte enables. A transaction-level reference memory predicts every B and R
// response. One compare process checks each cycle where a response is valid.
// Directed scenarios pin the model with literal values. A randomized phase
// follows them.
// ---------------------------------------------------------------------------
module tb_axi4lite_sram_bridge;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rexp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          loadMem = 1'b1;
    logic [AW-1:0] s_awaddr = '0;
    logic          s_awvalid = 1'b0;
    logic          s_awready;
    logic [DW-1:0] s_wdata = '0;
    logic [SW-1:0] s_wstrb = '0;
    logic          s_wvalid = 1'b0;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready = 1'b0;
    logic [AW-1:0] s_araddr = '0;
    logic          s_arvalid = 1'b0;
    logic          s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready = 1'b0;
    logic [AW-1:0] sram_waddr;
    logic [SW-1:0] sram_wstrb;
    logic [DW-1:0] sram_wdata;
    logic [AW-1:0] sram_raddr;
    logic [DW-1:0] sram_rdata;

    logic [DW-1:0] sramMem [0:1023];
    logic [DW-1:0] refMem  [0:1023];
    logic [1:0]    bq [$];
    rexp_t         rq [$];

    int checkCount = 0;
    int passCount = 0;
    int commitCount = 0;

    axi4lite_sram_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .sram_waddr(sram_waddr), .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata),
        .sram_raddr(sram_raddr), .sram_rdata(sram_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] initWord(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Behavioural SyncRam. The read samples the old contents before the
    // write lands, which makes it read-first.
    always @(posedge clock) begin
        if (loadMem) begin
            for (int i = 0; i < 1024; i++) sramMem[i] <= initWord(i);
        end else begin
            sram_rdata <= sramMem[sram_raddr[AW-1:2]];
            for (int b = 0; b < SW; b++) begin
                if (sram_wstrb[b]) sramMem[sram_waddr[AW-1:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
        end
    end

    // Counts the cycles in which the SRAM is actually asked to write.
    always @(negedge clock) begin
        if (!reset && sram_wstrb != '0) commitCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        else
            passCount++;
    endtask

    // Transaction-level model. A write merges its strobed bytes into the
    // reference memory and predicts its B response. A read predicts its R
    // beat from the memory as it stands when the read is issued.
    function automatic void modelWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb);
`ifdef AXI_SRAM_MISALIGN_ERR_EN
        if (addr[1:0] != 2'b00) begin
            bq.push_back(2'b10);
            return;
        end
`endif
        for (int b = 0; b < SW; b++)
            if (strb[b]) refMem[addr[AW-1:2]][b*8 +: 8] = data[b*8 +: 8];
        bq.push_back(2'b00);
    endfunction

    function automatic void modelRead(input logic [AW-1:0] addr);
        rexp_t e;
        e.data = refMem[addr[AW-1:2]];
        e.resp = 2'b00;
`ifdef AXI_SRAM_MISALIGN_ERR_EN
        if (addr[1:0] != 2'b00) begin
            e.data = '0;
            e.resp = 2'b10;
        end
`endif
        rq.push_back(e);
    endfunction

    // Compare process. Any valid response must match the head of its
    // expectation queue, and a response with nothing outstanding is an
    // error. The queue head is retired on the handshake. Reset discards
    // all outstanding expectations.
    always @(negedge clock) begin
        rexp_t e;
        if (reset) begin
            bq.delete();
            rq.delete();
        end else begin
            if (s_bvalid) begin
                if (bq.size() == 0) checkOutput("b_unexpected", 32'(s_bvalid), 32'd0);
                else begin
                    checkOutput("bresp", 32'(s_bresp), 32'(bq[0]));
                    if (s_bready) bq.delete(0);
                end
            end
            if (s_rvalid) begin
                if (rq.size() == 0) checkOutput("r_unexpected", 32'(s_rvalid), 32'd0);
                else begin
                    e = rq[0];
                    checkOutput("rdata", s_rdata, e.data);
                    checkOutput("rresp", 32'(s_rresp), 32'(e.resp));
                    if (s_rready) rq.delete(0);
                end
            end
        end
    end

    function automatic logic readyOf(input int ch);
        case (ch)
            0:       return s_awready;
            1:       return s_wready;
            default: return s_arready;
        endcase
    endfunction

    task automatic waitReady(input int ch, input string name);
        int n = 0;
        @(negedge clock);
        while (!readyOf(ch) && n < 64) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, 32'(readyOf(ch)), 32'd1);
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clock); #1; end
    endtask

    task automatic writeTxn(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                            input int awDelay, input int wDelay, input int bDelay, output logic [1:0] resp);
        int n = 0;
        modelWrite(addr, data, strb);
        fork
            begin
                idle(awDelay);
                s_awaddr = addr;
                s_awvalid = 1'b1;
                waitReady(0, "aw_accept");
                s_awvalid = 1'b0;
            end
            begin
                idle(wDelay);
                s_wdata = data;
                s_wstrb = strb;
                s_wvalid = 1'b1;
                waitReady(1, "w_accept");
                s_wvalid = 1'b0;
            end
        join
        for (int i = 0; i < bDelay; i++) begin
            @(negedge clock);
            checkOutput("aw_blocked", 32'(s_awready), 32'd0);
            checkOutput("w_blocked", 32'(s_wready), 32'd0);
            @(posedge clock); #1;
        end
        s_bready = 1'b1;
        @(negedge clock);
        while (!s_bvalid && n < 64) begin @(negedge clock); n++; end
        checkOutput("b_arrive", 32'(s_bvalid), 32'd1);
        resp = s_bresp;
        @(posedge clock); #1;
        s_bready = 1'b0;
    endtask

    task automatic readTxn(input logic [AW-1:0] addr, input int arDelay, input int rDelay,
                           output logic [DW-1:0] data, output logic [1:0] resp);
        int n = 0;
        modelRead(addr);
        idle(arDelay);
        s_araddr = addr;
        s_arvalid = 1'b1;
        waitReady(2, "ar_accept");
        s_arvalid = 1'b0;
        for (int i = 0; i < rDelay; i++) begin
            @(negedge clock);
            checkOutput("ar_blocked", 32'(s_arready), 32'd0);
            @(posedge clock); #1;
        end
        s_rready = 1'b1;
        @(negedge clock);
        while (!s_rvalid && n < 64) begin @(negedge clock); n++; end
        checkOutput("r_arrive", 32'(s_rvalid), 32'd1);
        data = s_rdata;
        resp = s_rresp;
        @(posedge clock); #1;
        s_rready = 1'b0;
    endtask

    // Accepts all outstanding B and R beats and remembers the last read data.
    task automatic drainResponses(output logic [DW-1:0] lastData);
        int n = 0;
        lastData = '0;
        s_bready = 1'b1;
        s_rready = 1'b1;
        while (n < 64) begin
            @(negedge clock);
            if (s_rvalid) lastData = s_rdata;
            if (bq.size() == 0 && rq.size() == 0) break;
            n++;
        end
        checkOutput("drain_done", 32'(bq.size() + rq.size()), 32'd0);
        @(posedge clock); #1;
        s_bready = 1'b0;
        s_rready = 1'b0;
    endtask

    task automatic applyStimulus(input int count);
        logic [AW-1:0] addr;
        logic [DW-1:0] d;
        logic [1:0]    r;
        for (int i = 0; i < count; i++) begin
            addr = 12'({$urandom_range(0, 15), 2'b00});
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1)
                writeTxn(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3), r);
            else
                readTxn(addr, $urandom_range(0, 2), $urandom_range(0, 3), d, r);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        logic [1:0]    r;
        int            c0;

        for (int i = 0; i < 1024; i++) refMem[i] = initWord(i);

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_awready", 32'(s_awready), 32'd0);
        checkOutput("rst_arready", 32'(s_arready), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        loadMem = 1'b0;
        @(negedge clock);
        checkOutput("rst_bvalid", 32'(s_bvalid), 32'd0);
        checkOutput("rst_rvalid", 32'(s_rvalid), 32'd0);
        checkOutput("rst_wstrb", 32'(sram_wstrb), 32'd0);
        checkOutput("rst_rdata", s_rdata, 32'd0);
        checkOutput("rst_resps", 32'({s_bresp, s_rresp}), 32'd0);
        checkOutput("rel_readies", 32'({s_awready, s_wready, s_arready}), 32'b111);
        @(posedge clock); #1;

        // AW and W in the same cycle, with cycle-exact timing
        s_awaddr = 12'h100; s_awvalid = 1'b1;
        s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
        modelWrite(12'h100, 32'hDEAD_BEEF, 4'hF);
        @(negedge clock);
        checkOutput("t1_aw_w_ready", 32'({s_awready, s_wready}), 32'b11);
        @(posedge clock); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clock);
        checkOutput("t1_commit_strb", 32'(sram_wstrb), 32'hF);
        checkOutput("t1_commit_addr", 32'(sram_waddr), 32'h100);
        checkOutput("t1_commit_data", sram_wdata, 32'hDEAD_BEEF);
        checkOutput("t1_bvalid_early", 32'(s_bvalid), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("t1_bvalid_2cyc", 32'(s_bvalid), 32'd1);
        checkOutput("t1_strb_closed", 32'(sram_wstrb), 32'd0);
        checkOutput("t1_bresp", 32'(s_bresp), 32'd0);
        @(posedge clock); #1;
        s_bready = 1'b1;
        @(posedge clock); #1;
        s_bready = 1'b0;

        s_araddr = 12'h100; s_arvalid = 1'b1;
        modelRead(12'h100);
        @(negedge clock);
        checkOutput("t1_arready", 32'(s_arready), 32'd1);
        checkOutput("t1_raddr", 32'(sram_raddr), 32'h100);
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        @(negedge clock);
        checkOutput("t1_rvalid_early", 32'(s_rvalid), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("t1_rvalid_2cyc", 32'(s_rvalid), 32'd1);
        checkOutput("t1_rdata", s_rdata, 32'hDEAD_BEEF);
        @(posedge clock); #1;
        s_rready = 1'b1;
        @(posedge clock); #1;
        s_rready = 1'b0;

        // W three cycles ahead of AW, partial strobe over an all-ones word
        writeTxn(12'h104, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
        c0 = commitCount;
        writeTxn(12'h104, 32'h1122_3344, 4'h3, 3, 0, 0, r);
        checkOutput("t2_single_commit", 32'(commitCount - c0), 32'd1);
        checkOutput("t2_model_word", refMem[12'h104 >> 2], 32'hFFFF_3344);
        readTxn(12'h104, 0, 0, d, r);
        checkOutput("t2_readback", d, 32'hFFFF_3344);

        // Read of the word being committed stalls one cycle, then sees new data
        writeTxn(12'h200, 32'h1357_9BDF, 4'hF, 0, 0, 0, r);
        s_awaddr = 12'h100; s_awvalid = 1'b1;
        s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
        modelWrite(12'h100, 32'h0BAD_F00D, 4'hF);
        @(negedge clock);
        @(posedge clock); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 12'h100; s_arvalid = 1'b1;
        @(negedge clock);
        checkOutput("t3_in_commit", 32'(sram_wstrb), 32'hF);
        checkOutput("t3_hazard_stall", 32'(s_arready), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("t3_hazard_release", 32'(s_arready), 32'd1);
        modelRead(12'h100);
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        drainResponses(d);
        checkOutput("t3_new_data", d, 32'h0BAD_F00D);

        // A different word read during commit goes through without a stall
        s_awaddr = 12'h100; s_awvalid = 1'b1;
        s_wdata = 32'h600D_CAFE; s_wstrb = 4'hF; s_wvalid = 1'b1;
        modelWrite(12'h100, 32'h600D_CAFE, 4'hF);
        @(negedge clock);
        @(posedge clock); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 12'h200; s_arvalid = 1'b1;
        @(negedge clock);
        checkOutput("t3b_no_stall", 32'(s_arready), 32'd1);
        modelRead(12'h200);
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        drainResponses(d);
        checkOutput("t3b_old_data", d, 32'h1357_9BDF);

        // Backpressure on B and R for five cycles
        writeTxn(12'h110, 32'hA1B2_C3D4, 4'hF, 0, 0, 5, r);
        readTxn(12'h110, 0, 5, d, r);
        checkOutput("t4_held_rdata", d, 32'hA1B2_C3D4);

        // Strobe of zero still completes OKAY without touching memory
        c0 = commitCount;
        writeTxn(12'h10C, 32'hFFFF_FFFF, 4'h0, 1, 0, 0, r);
        checkOutput("t5_zero_strb_commits", 32'(commitCount - c0), 32'd0);
        checkOutput("t5_zero_strb_bresp", 32'(r), 32'd0);
        readTxn(12'h10C, 0, 0, d, r);
        checkOutput("t5_unchanged", d, initWord(12'h10C >> 2));

        // Reset while the write sits in W_RESP and the read sits in R_WAIT
        s_awaddr = 12'h300; s_awvalid = 1'b1;
        s_wdata = 32'h7777_8888; s_wstrb = 4'hF; s_wvalid = 1'b1;
        modelWrite(12'h300, 32'h7777_8888, 4'hF);
        @(negedge clock);
        @(posedge clock); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 12'h304; s_arvalid = 1'b1;
        modelRead(12'h304);
        @(negedge clock);
        checkOutput("t6_ar_taken", 32'(s_arready), 32'd1);
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("t6_in_wresp", 32'(s_bvalid), 32'd1);
        checkOutput("t6_rst_readies", 32'({s_awready, s_wready, s_arready}), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("t6_valids_cleared", 32'({s_bvalid, s_rvalid}), 32'd0);
        checkOutput("t6_readies_low", 32'({s_awready, s_wready, s_arready}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("t6_no_stale", 32'({s_bvalid, s_rvalid}), 32'd0);
            checkOutput("t6_readies_back", 32'({s_awready, s_wready, s_arready}), 32'b111);
            @(posedge clock); #1;
        end
        readTxn(12'h300, 0, 0, d, r);
        checkOutput("t6_commit_kept", d, 32'h7777_8888);

        // Misaligned accesses
        writeTxn(12'h100, 32'hCAFE_F00D, 4'hF, 0, 0, 0, r);
        writeTxn(12'h102, 32'h1234_5678, 4'hF, 0, 0, 0, r);
`ifdef AXI_SRAM_MISALIGN_ERR_EN
        checkOutput("t7_mis_bresp", 32'(r), 32'h2);
`else
        checkOutput("t7_mis_bresp", 32'(r), 32'h0);
`endif
        readTxn(12'h101, 0, 0, d, r);
`ifdef AXI_SRAM_MISALIGN_ERR_EN
        checkOutput("t7_mis_rresp", 32'(r), 32'h2);
        checkOutput("t7_mis_rdata", d, 32'h0);
`else
        checkOutput("t7_mis_rresp", 32'(r), 32'h0);
        checkOutput("t7_mis_rdata", d, 32'h1234_5678);
`endif
        readTxn(12'h100, 0, 0, d, r);
`ifdef AXI_SRAM_MISALIGN_ERR_EN
        checkOutput("t7_word_100", d, 32'hCAFE_F00D);
`else
        checkOutput("t7_word_100", d, 32'h1234_5678);
`endif

        // Randomized traffic against the reference model
        applyStimulus(200);

        idle(4);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
